// File: rtl/serial_comp_pkg.sv
// Shared types and helpers for the bit-serial two's-complement datapath.
package serial_comp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // One extra bit so the counter never wraps, even at WIDTH = 2**n.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_comp_cell.sv
// Copy-until-first-one-then-invert cell: tracks whether a 1 has passed and
// inverts every later bit when complementing. Shared by serial tx and rx.
module serial_comp_cell (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic advance,
    input  logic bit_in,
    input  logic comp_en,
    output logic bit_out
);

    logic seen_one_q;
    logic seen_one_d;

    always_comb begin
        seen_one_d = seen_one_q;
        if (clear) begin
            seen_one_d = 1'b0;
        end else if (advance) begin
            seen_one_d = seen_one_q | bit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seen_one_q <= 1'b0;
        end else begin
            seen_one_q <= seen_one_d;
        end
    end

    assign bit_out = bit_in ^ (comp_en & seen_one_q);

endmodule

// File: rtl/serial_twos_comp_tx.sv
// Parallel-in, LSB-first serial-out transmitter that optionally sends the
// two's complement of each word over a valid/ready serial handshake.
//
//   state | meaning
//   IDLE  | ready for a new word, serial side idle
//   SHIFT | presenting bit cnt_q of the loaded word
module serial_twos_comp_tx
    import serial_comp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_comp_en,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_first,
    output logic             ser_last
);

    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             comp_q, comp_d;
    logic             load;
    logic             beat;
    logic             cell_bit;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        comp_d    = comp_q;
        load      = 1'b0;
        beat      = 1'b0;
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    sr_d    = in_data;
                    comp_d  = in_comp_en;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                if (ser_ready) begin
                    beat  = 1'b1;
                    sr_d  = sr_q >> 1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            comp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            comp_q  <= comp_d;
        end
    end

    serial_comp_cell u_cell (
        .clk     (clk),
        .reset   (reset),
        .clear   (load),
        .advance (beat),
        .bit_in  (sr_q[0]),
        .comp_en (comp_q),
        .bit_out (cell_bit)
    );

    // Gate with SHIFT so stale seen_one/comp state never leaks out while idle.
    assign ser_out   = (state_q == SHIFT) & cell_bit;
    assign ser_first = (state_q == SHIFT) & (cnt_q == '0);
    assign ser_last  = (state_q == SHIFT) & (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_serial_twos_comp_tx.sv
// Directed-vector bench for serial_twos_comp_tx at WIDTH = 8.
module tb_serial_twos_comp_tx;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_comp_en;
    logic       in_valid;
    logic       in_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_ready;
    logic       ser_first;
    logic       ser_last;

    int n_vec;
    int n_err;

    serial_twos_comp_tx #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_comp_en (in_comp_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .ser_first  (ser_first),
        .ser_last   (ser_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. Returns at the negedge of the
    // idle cycle following the last beat.
    task automatic run_word(input string tag, input logic [7:0] data, input logic comp,
                            input logic [7:0] exp, input bit stall, input bit hold,
                            input logic [7:0] next_data);
        logic [7:0] got;
        int beat;
        int cyc;
        got = '0;
        in_data    = data;
        in_comp_en = comp;
        in_valid   = 1'b1;
        ser_ready  = 1'b1;
        chk({tag, "_acc_rdy"}, 32'(in_ready), 32'd1);
        chk({tag, "_acc_sv"}, 32'(ser_valid), 32'd0);
        @(negedge clk);
        in_valid = hold;
        in_data  = next_data;
        beat = 0;
        cyc  = 0;
        while (beat < 8 && cyc < 64) begin
            ser_ready = stall ? (cyc % 3 == 0) : 1'b1;
            chk({tag, "_sv"}, 32'(ser_valid), 32'd1);
            chk({tag, "_ir"}, 32'(in_ready), 32'd0);
            chk({tag, "_out"}, 32'(ser_out), 32'(exp[beat]));
            chk({tag, "_first"}, 32'(ser_first), 32'(beat == 0));
            chk({tag, "_last"}, 32'(ser_last), 32'(beat == 7));
            if (ser_ready) begin
                got[beat] = ser_out;
                beat++;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_beats"}, 32'(beat), 32'd8);
        chk({tag, "_word"}, 32'(got), 32'(exp));
        chk({tag, "_end_rdy"}, 32'(in_ready), 32'd1);
        chk({tag, "_end_sv"}, 32'(ser_valid), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        chk({tag, "_sv"}, 32'(ser_valid), 32'd0);
        chk({tag, "_out"}, 32'(ser_out), 32'd0);
        chk({tag, "_first"}, 32'(ser_first), 32'd0);
        chk({tag, "_last"}, 32'(ser_last), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_c4;
        n_vec = 0;
        n_err = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_comp_en = 1'b0;
        ser_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("rst");
        reset = 1'b0;
        @(negedge clk);

        run_word("w06", 8'h06, 1'b1, 8'hFA, 1'b0, 1'b0, 8'h00);
        run_word("w01", 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);
        run_word("w00", 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
        run_word("w80", 8'h80, 1'b1, 8'h80, 1'b0, 1'b0, 8'h00);
        run_word("w7f", 8'h7F, 1'b1, 8'h81, 1'b0, 1'b0, 8'h00);
        run_word("pa5", 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00);
        run_word("s06", 8'h06, 1'b1, 8'hFA, 1'b1, 1'b0, 8'h00);

        // Abort 8'h3C (-> 8'hC4) after four beats.
        exp_c4     = 8'hC4;
        in_data    = 8'h3C;
        in_comp_en = 1'b1;
        in_valid   = 1'b1;
        ser_ready  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk("rst_pre_out", 32'(ser_out), 32'(exp_c4[b]));
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle("rst_mid");

        // Reset wins over a coincident handshake.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        chk_idle("rst_hs");
        @(negedge clk);
        chk_idle("rst_hs2");

        run_word("w02", 8'h02, 1'b1, 8'hFE, 1'b0, 1'b0, 8'h00);

        // Continuous in_valid with alternating words.
        run_word("h06", 8'h06, 1'b1, 8'hFA, 1'b0, 1'b1, 8'h01);
        run_word("h01", 8'h01, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h06);
        in_valid = 1'b0;
        @(negedge clk);
        chk_idle("post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
